// File: rtl/filt_pkg.sv
// filt_pkg: shared state encoding, filter-select codes and default sizing
// for the FIR initiator-side sequencer.
package filt_pkg;

  // Default sizing
  localparam int FILT_M         = 23;
  localparam int FILT_ADDR_SIZE = 5;
  localparam int FILT_DATA_SIZE = 16;
  localparam int FILT_SEL_SIZE  = 2;
  localparam int FILT_TIMEOUT   = 1023;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_WAIT_WR   = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_OUT       = 3'd5;

  // Coefficient bank selectors
  localparam logic [1:0] FSEL_LPF = 2'd0;
  localparam logic [1:0] FSEL_HPF = 2'd1;
  localparam logic [1:0] FSEL_BPF = 2'd2;

  // States in which the watchdog timer runs
  function automatic logic is_wait_state(input logic [2:0] st);
    return (st == ST_WAIT_WR) || (st == ST_START) || (st == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/filt_seq.sv
// filt_seq: per-sample sequencer around the ring buffer and the ap_ctrl FIR
// core. Accepts one sample, triggers the ring-buffer write, runs the filter,
// and hands the result out on a valid/ready port. Also owns the x_ant and
// coefficient BRAM address muxes so the filter never sees stale selects.
module filt_seq
  import filt_pkg::*;
#(
  parameter int M         = FILT_M,
  parameter int ADDR_SIZE = FILT_ADDR_SIZE,
  parameter int DATA_SIZE = FILT_DATA_SIZE,
  parameter int SEL_SIZE  = FILT_SEL_SIZE,
  parameter int TIMEOUT   = FILT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [DATA_SIZE-1:0]          s_data,
  output logic                          s_ready,
  input  logic [SEL_SIZE-1:0]           filt_select,
  output logic                          rbuf_start,
  output logic [DATA_SIZE-1:0]          rbuf_di,
  input  logic [ADDR_SIZE-1:0]          rbuf_addr,
  input  logic                          rbuf_en,
  input  logic                          rbuf_done,
  output logic                          ap_start,
  input  logic                          ap_ready,
  input  logic                          ap_done,
  input  logic [DATA_SIZE-1:0]          ap_return,
  input  logic [ADDR_SIZE-1:0]          filt_xant_addr,
  input  logic                          filt_xant_ce,
  input  logic [ADDR_SIZE-1:0]          filt_xcoefs_addr,
  output logic [ADDR_SIZE-1:0]          bram_xant_addr,
  output logic                          bram_xant_en,
  output logic [SEL_SIZE+ADDR_SIZE-1:0] bram_xcoefs_addr,
  output logic                          m_valid,
  output logic [DATA_SIZE-1:0]          m_data,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_MAX = ADDR_SIZE'(M - 1);

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [TW-1:0]       timer;
  logic                timer_hit;
  logic                capture;
  logic                abort;
  logic [SEL_SIZE-1:0] sel_q;
  logic                accept;

  // Abort fires on the last permitted cycle so at most TIMEOUT cycles are
  // spent in any waiting state.
  assign timer_hit = is_wait_state(state) && (timer == TW'(TIMEOUT - 1));
  assign accept    = (state == ST_IDLE) && s_valid && s_ready;

  // Next-state decode; handshake events win over a simultaneous timeout
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (rbuf_done) begin
          state_next = ST_START;
        end else if (timer_hit) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end
      end
      ST_START: begin
        if (ap_ready) begin
          if (ap_done) begin
            capture    = 1'b1;
            state_next = ST_OUT;
          end else begin
            state_next = ST_WAIT_DONE;
          end
        end else if (timer_hit) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (ap_done) begin
          capture    = 1'b1;
          state_next = ST_OUT;
        end else if (timer_hit) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; s_ready is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
    end else begin
      state   <= state_next;
      s_ready <= (state_next == ST_IDLE);
    end
  end

  // Watchdog: restarts on every state change, counts while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if (is_wait_state(state)) begin
      timer <= timer + 1'b1;
    end
  end

  // Latch the accepted sample and its coefficient bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_di <= '0;
      sel_q   <= '0;
    end else if (accept) begin
      rbuf_di <= s_data;
      sel_q   <= filt_select;
    end
  end

  // Capture the filter result; it stays stable while the result is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
    end else if (capture) begin
      m_data <= ap_return;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (abort) begin
      err_timeout <= 1'b1;
    end
  end

  assign rbuf_start = (state == ST_WRITE);
  assign ap_start   = (state == ST_START);
  assign m_valid    = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);

  // BRAM address mux: ring buffer owns x_ant during its write, the filter
  // otherwise; out-of-range filter addresses are clamped to 0
  always_comb begin
    bram_xant_en = rbuf_en | filt_xant_ce;
    if ((state == ST_WRITE) || (state == ST_WAIT_WR)) begin
      bram_xant_addr = rbuf_addr;
    end else if (filt_xant_addr > ADDR_MAX) begin
      bram_xant_addr = '0;
    end else begin
      bram_xant_addr = filt_xant_addr;
    end
    if (filt_xcoefs_addr > ADDR_MAX) begin
      bram_xcoefs_addr = '0;
    end else begin
      bram_xcoefs_addr = {sel_q, filt_xcoefs_addr};
    end
  end

endmodule

// File: tb/tb_filt_seq.sv
// tb_filt_seq: directed scenarios for the FIR sequencer with hand-computed
// expectations; one line per transaction, one summary line at the end.
module tb_filt_seq;
  import filt_pkg::*;

  localparam int M         = 23;
  localparam int ADDR_SIZE = 5;
  localparam int DATA_SIZE = 16;
  localparam int SEL_SIZE  = 2;
  localparam int TIMEOUT   = 1023;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          s_valid;
  logic [DATA_SIZE-1:0]          s_data;
  logic                          s_ready;
  logic [SEL_SIZE-1:0]           filt_select;
  logic                          rbuf_start;
  logic [DATA_SIZE-1:0]          rbuf_di;
  logic [ADDR_SIZE-1:0]          rbuf_addr;
  logic                          rbuf_en;
  logic                          rbuf_done;
  logic                          ap_start;
  logic                          ap_ready;
  logic                          ap_done;
  logic [DATA_SIZE-1:0]          ap_return;
  logic [ADDR_SIZE-1:0]          filt_xant_addr;
  logic                          filt_xant_ce;
  logic [ADDR_SIZE-1:0]          filt_xcoefs_addr;
  logic [ADDR_SIZE-1:0]          bram_xant_addr;
  logic                          bram_xant_en;
  logic [SEL_SIZE+ADDR_SIZE-1:0] bram_xcoefs_addr;
  logic                          m_valid;
  logic [DATA_SIZE-1:0]          m_data;
  logic                          m_ready;
  logic                          busy;
  logic                          err_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int rbuf_start_cnt = 0;
  int m_valid_cnt = 0;

  filt_seq #(
    .M(M), .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE),
    .SEL_SIZE(SEL_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .filt_select(filt_select),
    .rbuf_start(rbuf_start), .rbuf_di(rbuf_di), .rbuf_addr(rbuf_addr),
    .rbuf_en(rbuf_en), .rbuf_done(rbuf_done),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_return(ap_return),
    .filt_xant_addr(filt_xant_addr), .filt_xant_ce(filt_xant_ce),
    .filt_xcoefs_addr(filt_xcoefs_addr),
    .bram_xant_addr(bram_xant_addr), .bram_xant_en(bram_xant_en),
    .bram_xcoefs_addr(bram_xcoefs_addr),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (rbuf_start === 1'b1) rbuf_start_cnt++;
    if (m_valid === 1'b1) m_valid_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_valid = 0; s_data = '0; filt_select = '0; rbuf_addr = '0; rbuf_en = 0;
    rbuf_done = 0; ap_ready = 0; ap_done = 0; ap_return = '0; filt_xant_addr = '0;
    filt_xant_ce = 0; filt_xcoefs_addr = '0; m_ready = 0;
    tick(3);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b need 0", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_cmp++; if ({rbuf_start, ap_start, m_valid, err_timeout} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b need 0000", {rbuf_start, ap_start, m_valid, err_timeout}); end
    n_cmp++; if ({rbuf_di, m_data} !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d/%0d need 0/0", rbuf_di, m_data); end
    n_cmp++; if ({bram_xant_addr, bram_xant_en, bram_xcoefs_addr} !== 13'd0) begin n_bad++; $display("FAIL reset_bram: got %0d/%b/%0d need 0", bram_xant_addr, bram_xant_en, bram_xcoefs_addr); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL release_s_ready_pre_edge: got %b need 0", s_ready); end
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL first_idle_s_ready: got %b need 1", s_ready); end
    $display("reset: done, s_ready=%b busy=%b", s_ready, busy);
  endtask

  // Sample 100 on BPF; leaves the DUT in WAIT_DONE
  task automatic test_single_sample(output int start_pulses0);
    start_pulses0 = rbuf_start_cnt;
    s_valid = 1; s_data = 16'd100; filt_select = FSEL_BPF;
    tick();
    s_valid = 0; s_data = '0;
    n_cmp++; if (rbuf_start !== 1'b1) begin n_bad++; $display("FAIL write_rbuf_start: got %b need 1", rbuf_start); end
    n_cmp++; if (rbuf_di !== 16'd100) begin n_bad++; $display("FAIL write_rbuf_di: got %0d need 100", rbuf_di); end
    n_cmp++; if ({s_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL write_ready_busy: got %b need 01", {s_ready, busy}); end
    rbuf_addr = 5'd7; rbuf_en = 1; filt_xant_addr = 5'd3; #1;
    n_cmp++; if (bram_xant_addr !== 5'd7) begin n_bad++; $display("FAIL write_xant_mux: got %0d need 7", bram_xant_addr); end
    n_cmp++; if (bram_xant_en !== 1'b1) begin n_bad++; $display("FAIL write_xant_en: got %b need 1", bram_xant_en); end
    tick();
    n_cmp++; if ({rbuf_start, bram_xant_addr} !== {1'b0, 5'd7}) begin n_bad++; $display("FAIL waitwr_pulse_mux: got %b/%0d need 0/7", rbuf_start, bram_xant_addr); end
    tick(2);
    rbuf_en = 0; rbuf_done = 1;
    tick();
    rbuf_done = 0;
    n_cmp++; if (ap_start !== 1'b1) begin n_bad++; $display("FAIL start_ap_start: got %b need 1", ap_start); end
    n_cmp++; if (bram_xant_addr !== 5'd3) begin n_bad++; $display("FAIL start_xant_mux: got %0d need 3", bram_xant_addr); end
    tick(3);
    n_cmp++; if (ap_start !== 1'b1) begin n_bad++; $display("FAIL start_held: got %b need 1", ap_start); end
    ap_ready = 1;
    tick();
    ap_ready = 0;
    n_cmp++; if (ap_start !== 1'b0) begin n_bad++; $display("FAIL waitdone_ap_start: got %b need 0", ap_start); end
    n_cmp++; if (rbuf_start_cnt - start_pulses0 !== 1) begin n_bad++; $display("FAIL rbuf_start_pulses: got %0d need 1", rbuf_start_cnt - start_pulses0); end
    $display("sample: data=100 sel=BPF accepted, filter started");
  endtask

  task automatic test_addr_mux;
    logic [SEL_SIZE+ADDR_SIZE-1:0] c;
    filt_xant_addr = 5'd23; filt_xcoefs_addr = 5'd31; #1;
    n_cmp++; if (bram_xant_addr !== 5'd0) begin n_bad++; $display("FAIL xant_clamp_23: got %0d need 0", bram_xant_addr); end
    n_cmp++; if (bram_xcoefs_addr !== 7'd0) begin n_bad++; $display("FAIL xcoefs_clamp_31: got %0d need 0", bram_xcoefs_addr); end
    filt_xant_addr = 5'd22; filt_xcoefs_addr = 5'd22; #1;
    n_cmp++; if (bram_xant_addr !== 5'd22) begin n_bad++; $display("FAIL xant_addr_22: got %0d need 22", bram_xant_addr); end
    n_cmp++; if (bram_xcoefs_addr !== 7'd86) begin n_bad++; $display("FAIL xcoefs_addr_22: got %0d need 86", bram_xcoefs_addr); end
    filt_xant_ce = 1; #1;
    n_cmp++; if (bram_xant_en !== 1'b1) begin n_bad++; $display("FAIL xant_en_ce: got %b need 1", bram_xant_en); end
    filt_xant_ce = 0; #1;
    n_cmp++; if (bram_xant_en !== 1'b0) begin n_bad++; $display("FAIL xant_en_idle: got %b need 0", bram_xant_en); end
    filt_xcoefs_addr = 5'd5; #1;
    c = bram_xcoefs_addr;
    n_cmp++; if (c[6:5] !== 2'd2) begin n_bad++; $display("FAIL xcoefs_bank_bpf: got %0d need 2", c[6:5]); end
    $display("addr_mux: clamp and pass-through checked");
  endtask

  task automatic test_sel_change;
    logic [SEL_SIZE+ADDR_SIZE-1:0] c;
    filt_select = FSEL_LPF;
    tick();
    c = bram_xcoefs_addr;
    n_cmp++; if (c[6:5] !== 2'd2) begin n_bad++; $display("FAIL sel_change_bank: got %0d need 2", c[6:5]); end
    n_cmp++; if (c !== 7'd69) begin n_bad++; $display("FAIL sel_change_addr: got %0d need 69", c); end
    $display("sel_change: filt_select 2->0 mid-run, bank stays %0d", c[6:5]);
  endtask

  // Finish the 30-cycle filter run; model result for 100 at gain 3 is 300
  task automatic test_result;
    tick(28);
    ap_done = 1; ap_return = 16'd300;
    tick();
    ap_done = 0; ap_return = 16'hDEAD;
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL result_valid: got %b need 1", m_valid); end
    n_cmp++; if (m_data !== 16'd300) begin n_bad++; $display("FAIL result_data: got %0d need 300", m_data); end
    $display("result: m_data=%0d", m_data);
  endtask

  task automatic test_hold(input int start_pulses0);
    s_valid = 1; s_data = 16'd555;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++; if ({m_valid, s_ready, m_data} !== {1'b1, 1'b0, 16'd300}) begin n_bad++; $display("FAIL hold_cycle%0d: got v=%b r=%b d=%0d need 1/0/300", i, m_valid, s_ready, m_data); end
    end
    s_valid = 0; s_data = '0; m_ready = 1;
    tick();
    m_ready = 0;
    n_cmp++; if ({m_valid, busy, s_ready} !== 3'b001) begin n_bad++; $display("FAIL handshake_idle: got %b need 001", {m_valid, busy, s_ready}); end
    n_cmp++; if (rbuf_di !== 16'd100) begin n_bad++; $display("FAIL no_overwrite: got %0d need 100", rbuf_di); end
    n_cmp++; if (rbuf_start_cnt - start_pulses0 !== 1) begin n_bad++; $display("FAIL second_sample_consumed: got %0d pulses need 1", rbuf_start_cnt - start_pulses0); end
    $display("hold: 50 stall cycles, result delivered");
  endtask

  task automatic test_stray;
    rbuf_done = 1; ap_done = 1; ap_return = 16'd77;
    tick();
    rbuf_done = 0; ap_done = 0; ap_return = '0;
    n_cmp++; if ({busy, m_valid, ap_start} !== 3'b000) begin n_bad++; $display("FAIL stray_state: got %b need 000", {busy, m_valid, ap_start}); end
    n_cmp++; if (m_data !== 16'd300) begin n_bad++; $display("FAIL stray_capture: got %0d need 300", m_data); end
    $display("stray: pulses in IDLE ignored");
  endtask

  task automatic test_timeout;
    int mv0;
    mv0 = m_valid_cnt;
    s_valid = 1; s_data = 16'd7; filt_select = FSEL_HPF;
    tick();
    s_valid = 0;
    tick();
    rbuf_done = 1;
    tick();
    rbuf_done = 0; ap_ready = 1;
    tick();
    ap_ready = 0;
    tick(TIMEOUT - 1);
    n_cmp++; if ({busy, err_timeout} !== 2'b10) begin n_bad++; $display("FAIL timeout_last_cycle: got %b need 10", {busy, err_timeout}); end
    tick();
    n_cmp++; if ({busy, err_timeout, ap_start} !== 3'b010) begin n_bad++; $display("FAIL timeout_abort: got %b need 010", {busy, err_timeout, ap_start}); end
    tick(3);
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b need 1", err_timeout); end
    n_cmp++; if (m_valid_cnt - mv0 !== 0) begin n_bad++; $display("FAIL timeout_m_valid: got %0d cycles need 0", m_valid_cnt - mv0); end
    $display("timeout: err_timeout=%b after %0d cycles", err_timeout, TIMEOUT);
  endtask

  task automatic test_reset_mid;
    s_valid = 1; s_data = 16'd9; filt_select = FSEL_BPF;
    tick();
    s_valid = 0;
    tick();
    rbuf_done = 1;
    tick();
    rbuf_done = 0; ap_ready = 1;
    tick();
    ap_ready = 0; filt_xant_addr = '0; filt_xcoefs_addr = '0; rbuf_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, ap_start, m_valid, s_ready, rbuf_start, err_timeout} !== 6'b0) begin n_bad++; $display("FAIL async_reset_ctrl: got %b need 000000", {busy, ap_start, m_valid, s_ready, rbuf_start, err_timeout}); end
    n_cmp++; if ({rbuf_di, m_data, bram_xcoefs_addr} !== 39'd0) begin n_bad++; $display("FAIL async_reset_data: got %0d/%0d/%0d need 0", rbuf_di, m_data, bram_xcoefs_addr); end
    ap_done = 1; ap_return = 16'd999;
    @(negedge clk); rst_n = 1'b1; ap_done = 0; ap_return = '0;
    tick();
    n_cmp++; if ({s_ready, busy, m_valid} !== 3'b100) begin n_bad++; $display("FAIL post_reset_idle: got %b need 100", {s_ready, busy, m_valid}); end
    $display("reset_mid: async reset in WAIT_DONE");
  endtask

  // Normal sample after reset, ap_ready and ap_done arriving together
  task automatic test_back_to_back;
    s_valid = 1; s_data = 16'd40; filt_select = FSEL_LPF;
    tick();
    s_valid = 0;
    tick();
    rbuf_done = 1;
    tick();
    rbuf_done = 0; ap_ready = 1; ap_done = 1; ap_return = 16'd123;
    tick();
    ap_ready = 0; ap_done = 0; ap_return = '0; filt_xcoefs_addr = 5'd4;
    #1;
    n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'd123}) begin n_bad++; $display("FAIL fast_done_result: got %b/%0d need 1/123", m_valid, m_data); end
    n_cmp++; if (bram_xcoefs_addr !== 7'd4) begin n_bad++; $display("FAIL fast_done_bank: got %0d need 4", bram_xcoefs_addr); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL fast_done_err: got %b need 0", err_timeout); end
    m_ready = 1;
    tick();
    m_ready = 0;
    n_cmp++; if ({m_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL fast_done_release: got %b need 00", {m_valid, busy}); end
    $display("back_to_back: data=40 result=123");
  endtask

  initial begin
    int p0;
    test_reset();
    test_single_sample(p0);
    test_addr_mux();
    test_sel_change();
    test_result();
    test_hold(p0);
    test_stray();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
